// File: rtl/l2_arbiter_if.sv
// ============================================================================
// Module      : l2_arbiter_if
// Description : Bundles the icache, dcache and L2 handshake/bus signals seen by
//               the L2 arbiter. The arbiter uses the slave view and the
//               environment uses the master view.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface l2_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
);
    logic              icache_L2_read;
    logic [ADDR_W-1:0] icache_L2_address;
    logic [LINE_W-1:0] icache_L2_rdata;
    logic              icache_L2_resp;

    logic              dcache_L2_read;
    logic              dcache_L2_write;
    logic [ADDR_W-1:0] dcache_L2_address;
    logic [LINE_W-1:0] dcache_L2_wdata;
    logic [LINE_W-1:0] dcache_L2_rdata;
    logic              dcache_L2_resp;

    logic              L2_read;
    logic              L2_write;
    logic [ADDR_W-1:0] L2_address;
    logic [LINE_W-1:0] L2_wdata;
    logic [LINE_W-1:0] L2_rdata;
    logic              L2_resp;

    modport slave (
        input  icache_L2_read, icache_L2_address,
        input  dcache_L2_read, dcache_L2_write, dcache_L2_address, dcache_L2_wdata,
        input  L2_rdata, L2_resp,
        output icache_L2_rdata, icache_L2_resp,
        output dcache_L2_rdata, dcache_L2_resp,
        output L2_read, L2_write, L2_address, L2_wdata
    );

    modport master (
        output icache_L2_read, icache_L2_address,
        output dcache_L2_read, dcache_L2_write, dcache_L2_address, dcache_L2_wdata,
        output L2_rdata, L2_resp,
        input  icache_L2_rdata, icache_L2_resp,
        input  dcache_L2_rdata, dcache_L2_resp,
        input  L2_read, L2_write, L2_address, L2_wdata
    );
endinterface

`default_nettype wire

// File: rtl/l2_arbiter.sv
// ============================================================================
// Module      : l2_arbiter
// Description : Multiplexes the icache fill port and dcache fill/write-back port
//               onto one L2 port. Fixed dcache priority by default; defining
//               L2_ARB_ROUND_ROBIN_EN enables round-robin tie breaking.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module l2_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    l2_arbiter_if.slave  bus,
    output logic         grant_d
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_l2_read;
    logic              r_l2_write;
    logic [ADDR_W-1:0] r_l2_address;
    logic [LINE_W-1:0] r_l2_wdata;
    logic              w_l2_read;
    logic              w_l2_write;
    logic [ADDR_W-1:0] w_l2_address;
    logic [LINE_W-1:0] w_l2_wdata;
    logic              w_req_i;
    logic              w_req_d;
    logic              w_pick_d;

    assign w_req_i = bus.icache_L2_read;
    assign w_req_d = bus.dcache_L2_read | bus.dcache_L2_write;

`ifdef L2_ARB_ROUND_ROBIN_EN
    logic r_rr_last;  // 0 = icache served last, 1 = dcache served last

    assign w_pick_d = w_req_d & (~w_req_i | ~r_rr_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_last <= 1'b0;
        end else if (r_state == IDLE && w_next_state == SERVE_D) begin
            r_rr_last <= 1'b1;
        end else if (r_state == IDLE && w_next_state == SERVE_I) begin
            r_rr_last <= 1'b0;
        end
    end
`else
    assign w_pick_d = w_req_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_l2_read    <= 1'b0;
            r_l2_write   <= 1'b0;
            r_l2_address <= '0;
            r_l2_wdata   <= '0;
        end else begin
            r_state      <= w_next_state;
            r_l2_read    <= w_l2_read;
            r_l2_write   <= w_l2_write;
            r_l2_address <= w_l2_address;
            r_l2_wdata   <= w_l2_wdata;
        end
    end

    // Requests are only sampled in IDLE, so the mandatory IDLE cycle after a
    // response keeps a still-asserted request from being re-granted.
    always_comb begin
        w_next_state = r_state;
        w_l2_read    = r_l2_read;
        w_l2_write   = r_l2_write;
        w_l2_address = r_l2_address;
        w_l2_wdata   = r_l2_wdata;
        case (r_state)
            IDLE: begin
                if (w_pick_d) begin
                    w_next_state = SERVE_D;
                    w_l2_write   = bus.dcache_L2_write;
                    w_l2_read    = bus.dcache_L2_read & ~bus.dcache_L2_write;
                    w_l2_address = bus.dcache_L2_address;
                    w_l2_wdata   = bus.dcache_L2_wdata;
                end else if (w_req_i) begin
                    w_next_state = SERVE_I;
                    w_l2_write   = 1'b0;
                    w_l2_read    = 1'b1;
                    w_l2_address = bus.icache_L2_address;
                    w_l2_wdata   = '0;
                end
            end
            SERVE_I, SERVE_D: begin
                if (bus.L2_resp) begin
                    w_next_state = IDLE;
                    w_l2_read    = 1'b0;
                    w_l2_write   = 1'b0;
                    w_l2_address = '0;
                    w_l2_wdata   = '0;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_l2_read    = 1'b0;
                w_l2_write   = 1'b0;
                w_l2_address = '0;
                w_l2_wdata   = '0;
            end
        endcase
    end

    assign bus.L2_read         = r_l2_read;
    assign bus.L2_write        = r_l2_write;
    assign bus.L2_address      = r_l2_address;
    assign bus.L2_wdata        = r_l2_wdata;
    assign bus.icache_L2_resp  = (r_state == SERVE_I) & bus.L2_resp;
    assign bus.dcache_L2_resp  = (r_state == SERVE_D) & bus.L2_resp;
    assign bus.icache_L2_rdata = (r_state == SERVE_I) ? bus.L2_rdata : '0;
    assign bus.dcache_L2_rdata = (r_state == SERVE_D) ? bus.L2_rdata : '0;
    assign grant_d             = (r_state == SERVE_D);

endmodule

`default_nettype wire

// File: tb/tb_l2_arbiter.sv
// ============================================================================
// Module      : tb_l2_arbiter
// Description : Directed and randomized bench for l2_arbiter against a
//               transaction-level reference model of the arbitration rules.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_l2_arbiter;
    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;
    localparam int OWN_NONE = 0;
    localparam int OWN_I    = 1;
    localparam int OWN_D    = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic grant_d;

    always #5 clk = ~clk;

    l2_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    l2_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .grant_d (grant_d)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: who owns L2, the captured transaction, and who was last served.
    int                m_owner;
    int                m_last;
    logic              m_rd;
    logic              m_wr;
    logic [ADDR_W-1:0] m_addr;
    logic [LINE_W-1:0] m_wdata;

    task automatic check_val(input string tag, input logic [LINE_W-1:0] act,
                             input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = OWN_NONE;
        m_last  = OWN_I;
        m_rd    = 1'b0;
        m_wr    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
    endtask

    function automatic logic [LINE_W-1:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Apply the arbitration rules to the inputs present at a rising edge.
    task automatic model_edge();
        bit want_i, want_d, take_d;
        if (m_owner != OWN_NONE) begin
            if (bus.L2_resp) begin
                m_owner = OWN_NONE;
                m_rd = 1'b0; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
            end
        end else begin
            want_i = bus.icache_L2_read;
            want_d = bus.dcache_L2_read || bus.dcache_L2_write;
`ifdef L2_ARB_ROUND_ROBIN_EN
            take_d = want_d && (!want_i || m_last == OWN_I);
`else
            take_d = want_d;
`endif
            if (take_d) begin
                m_owner = OWN_D;
                m_last  = OWN_D;
                m_wr    = bus.dcache_L2_write;
                m_rd    = !bus.dcache_L2_write;
                m_addr  = bus.dcache_L2_address;
                m_wdata = bus.dcache_L2_wdata;
            end else if (want_i) begin
                m_owner = OWN_I;
                m_last  = OWN_I;
                m_rd    = 1'b1;
                m_wr    = 1'b0;
                m_addr  = bus.icache_L2_address;
                m_wdata = '0;
            end
        end
    endtask

    task automatic check_outputs();
        bit i_own, d_own;
        i_own = (m_owner == OWN_I);
        d_own = (m_owner == OWN_D);
        check_val("L2_read",    LINE_W'(bus.L2_read),    LINE_W'(m_rd));
        check_val("L2_write",   LINE_W'(bus.L2_write),   LINE_W'(m_wr));
        check_val("L2_address", LINE_W'(bus.L2_address), LINE_W'(m_addr));
        check_val("L2_wdata",   bus.L2_wdata,            m_wdata);
        check_val("grant_d",    LINE_W'(grant_d),        LINE_W'(d_own));
        check_val("icache_resp", LINE_W'(bus.icache_L2_resp), LINE_W'(i_own && bus.L2_resp));
        check_val("dcache_resp", LINE_W'(bus.dcache_L2_resp), LINE_W'(d_own && bus.L2_resp));
        check_val("icache_rdata", bus.icache_L2_rdata, i_own ? bus.L2_rdata : '0);
        check_val("dcache_rdata", bus.dcache_L2_rdata, d_own ? bus.L2_rdata : '0);
    endtask

    // Inputs are set just after a falling edge; check, then cross one rising edge.
    task automatic step();
        #1 check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.icache_L2_read    = 1'b0;
        bus.icache_L2_address = '0;
        bus.dcache_L2_read    = 1'b0;
        bus.dcache_L2_write   = 1'b0;
        bus.dcache_L2_address = '0;
        bus.dcache_L2_wdata   = '0;
        bus.L2_rdata          = '0;
        bus.L2_resp           = 1'b0;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        rst_n = 1'b0;
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        step();

        // icache fill 0x1230 answered with 0xA5..A5
        bus.icache_L2_read = 1'b1; bus.icache_L2_address = 16'h1230;
        step();
        check_val("i_read_latency", LINE_W'(bus.L2_read), LINE_W'(1));
        bus.icache_L2_read = 1'b0;
        step();
        bus.L2_resp = 1'b1; bus.L2_rdata = {16{8'hA5}};
        #1 check_val("i_rdata_a5", bus.icache_L2_rdata, {16{8'hA5}});
        step();
        bus.L2_resp = 1'b0;
        step();

        // dcache write-back, request dropped mid-wait
        bus.dcache_L2_write = 1'b1; bus.dcache_L2_address = 16'h4440;
        bus.dcache_L2_wdata = {32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        step();
        bus.dcache_L2_write = 1'b0; bus.dcache_L2_wdata = '0; bus.dcache_L2_address = 16'h0;
        step(); step();
        bus.L2_resp = 1'b1;
        step();
        bus.L2_resp = 1'b0;
        step();

        // Simultaneous icache 0x0100 and dcache 0x8000, held until served
        for (int n = 0; n < 3; n++) begin
            bus.icache_L2_read = 1'b1; bus.icache_L2_address = 16'h0100;
            bus.dcache_L2_read = 1'b1; bus.dcache_L2_address = 16'h8000;
            step(); step();
            bus.L2_resp = 1'b1; bus.L2_rdata = rnd_line();
            if (m_owner == OWN_D) bus.dcache_L2_read = 1'b0;
            else                  bus.icache_L2_read = 1'b0;
            step();
            bus.L2_resp = 1'b0;
            step(); step();
            bus.L2_resp = 1'b1;
            step();
            clear_inputs();
            step();
        end

        // Read and write together count as a write
        bus.dcache_L2_read = 1'b1; bus.dcache_L2_write = 1'b1; bus.dcache_L2_address = 16'h2220;
        bus.dcache_L2_wdata = rnd_line();
        step();
        check_val("rw_is_write", {bus.L2_write, bus.L2_read}, 2'b10);
        clear_inputs();
        bus.L2_resp = 1'b1;
        step();
        bus.L2_resp = 1'b0;
        step();

        // Asynchronous reset while dcache owns L2, icache pending
        bus.dcache_L2_read = 1'b1; bus.dcache_L2_address = 16'h3330;
        step();
        bus.dcache_L2_read = 1'b0;
        bus.icache_L2_read = 1'b1; bus.icache_L2_address = 16'h5550;
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_val("post_reset_i_grant", LINE_W'(bus.L2_address), LINE_W'(16'h5550));
        bus.icache_L2_read = 1'b0;
        bus.L2_resp = 1'b1;
        step();
        bus.L2_resp = 1'b0;
        step();

        // Stray L2_resp while idle
        bus.L2_resp = 1'b1; bus.L2_rdata = rnd_line();
        step();
        bus.L2_resp = 1'b0;
        step();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) bus.icache_L2_read = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) begin
                bus.dcache_L2_read  = ($urandom_range(0, 2) == 0);
                bus.dcache_L2_write = ($urandom_range(0, 2) == 0);
            end
            if ($urandom_range(0, 2) == 0) bus.icache_L2_address = ADDR_W'($urandom);
            if ($urandom_range(0, 2) == 0) bus.dcache_L2_address = ADDR_W'($urandom);
            if ($urandom_range(0, 2) == 0) bus.dcache_L2_wdata = rnd_line();
            bus.L2_rdata = rnd_line();
            bus.L2_resp  = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

`default_nettype wire

// File: doc/l2_arbiter.md
Name: l2_arbiter

Overview:
- Sits directly downstream of the split L1 caches; multiplexes the icache and dcache line-fill/write-back ports onto the single L2 port.
- Consumes the dcache controller's L2_read / L2_write / L2_resp handshake unchanged; the icache side is read-only.
- Grants one client at a time, latches its request, and holds it toward L2 until L2_resp. Routes read data and response back to the granted client only.

Parameters:
ADDR_W, 16, byte address width (lc3b address)
LINE_W, 128, cache line width in bits

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
icache_L2_read  input  1  icache line-fill request
icache_L2_address  input  ADDR_W  icache line address
icache_L2_rdata  output  LINE_W  fill data to icache
icache_L2_resp  output  1  icache transaction complete
dcache_L2_read  input  1  dcache line-fill request
dcache_L2_write  input  1  dcache write-back request
dcache_L2_address  input  ADDR_W  dcache line address (already muxed by dcache pmemaddressmux)
dcache_L2_wdata  input  LINE_W  dcache write-back line
dcache_L2_rdata  output  LINE_W  fill data to dcache
dcache_L2_resp  output  1  dcache transaction complete
L2_read  output  1  read request to L2
L2_write  output  1  write request to L2
L2_address  output  ADDR_W  latched request address
L2_wdata  output  LINE_W  latched write data
L2_rdata  input  LINE_W  L2 read data
L2_resp  input  1  L2 transaction complete
grant_d  output  1  1 while dcache owns L2 (debug/perf)

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- States: IDLE, SERVE_I, SERVE_D.
- Reset (asynchronous, any cycle, including mid-transaction): state=IDLE.
  - Outputs: L2_read=0, L2_write=0, L2_address=0, L2_wdata=0, both resp=0, grant_d=0.
  - Internal registers: rr_last=0.
  - An in-flight L2 transaction is abandoned. The L2 owner must also be reset.
- IDLE:
  - Sample requests. A dcache request is dcache_L2_read|dcache_L2_write; an icache request is icache_L2_read.
  - On a grant, register address, wdata and op into output registers at that clock edge, then enter SERVE_x.
  - L2_read/L2_write therefore assert in the cycle after the request is first seen (1-cycle arbitration latency).
  - No request: stay in IDLE, L2 outputs 0.
- Priority when both request in the same IDLE cycle: dcache wins (fixed priority; see Optional Feature).
- dcache_L2_read and dcache_L2_write both high: treated as write. L2_write=1, L2_read=0.
- SERVE_I / SERVE_D:
  - L2 outputs are held from registers and are independent of client inputs, so a client dropping its request mid-transaction does not abort it.
  - Wait for L2_resp.
  - In the cycle L2_resp=1, the granted client sees {x}_L2_resp=1 combinationally and {x}_L2_rdata=L2_rdata. The next state is IDLE.
- Non-granted client: resp=0 always; its rdata is don't-care and is driven 0.
- After a response, the arbiter spends one IDLE cycle before the next grant. This prevents a client that still holds its request in the resp cycle from being re-granted spuriously.
  - The dcache controller leaves MISS/WRITE_BACK on resp, so its request drops in time.
- Back-to-back dcache write-back then fill: each is a separate grant. The icache may be granted between them if it is pending and wins under the active policy.
- grant_d=1 exactly in SERVE_D.
- L2_resp while IDLE: ignored, no client resp.

Optional Feature:
- Macro: L2_ARB_ROUND_ROBIN_EN.
- Defined:
  - Round-robin on simultaneous requests. rr_last records the last served client (0=icache, 1=dcache), updated on entering SERVE_x.
  - The client not served last wins the tie.
  - A single requester is always granted regardless of rr_last.
- Undefined: fixed dcache-over-icache priority; rr_last is not implemented.

Test Plan:
- Reset then icache_L2_read=1, address 0x1230. Expected: L2_read=1 and L2_address=0x1230 one cycle later. When L2_resp pulses with L2_rdata=0xA5..A5: icache_L2_resp=1 and icache_L2_rdata=0xA5..A5 that cycle; dcache_L2_resp=0.
- dcache_L2_write=1, address 0x4440, wdata=0xDEAD..BEEF. Expected: L2_write=1, L2_wdata latched. Dropping dcache_L2_write mid-wait does not change L2 outputs. dcache_L2_resp rises on L2_resp.
- Simultaneous icache read 0x0100 and dcache read 0x8000. Fixed priority: dcache served first, icache granted after the dcache resp plus one IDLE cycle. With the macro, repeated contention alternates grants I/D/I.
- dcache_L2_read and dcache_L2_write both 1. Expected: L2_write=1, L2_read=0.
- rst_n driven low during SERVE_D. Expected: immediately L2_read/L2_write=0 and state IDLE. After release, the icache request is granted normally.
- L2_resp pulse while IDLE. Expected: no client resp, state stays IDLE.
